q_episode_sequencer: RTL and testbench

Time-multiplexed controller for the Q-learning datapath. It runs N_EPISODES training episodes on one shared action-select unit (max-Q/reward), one Q-update unit and one maze-trial unit, instead of one unrolled copy of each per episode. It sits between the init/blocked-state stage (which asserts init_done) and the exploit stage (which waits on learn_done). Each unit is driven through a start-pulse/done handshake.

---
 rtl/q_episode_sequencer.sv | 148 ++++++++++++++
 tb/tb_q_episode_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/q_episode_sequencer.sv
// Time-multiplexes N_EPISODES Q-learning episodes over one shared action-select, Q-update and maze-trial unit.
// Define Q_SEQ_WATCHDOG_EN to add a 255-cycle per-handshake timeout that parks the FSM in FAULT.
module q_episode_sequencer #(
  parameter int N_EPISODES = 11,
  parameter int MAX_STEPS  = 36,
  localparam int EW = $clog2(N_EPISODES + 1),
  localparam int SW = $clog2(MAX_STEPS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          init_done,
  input  logic [5:0]    start_state,
  input  logic [5:0]    target_state,
  output logic          maxq_start,
  output logic [5:0]    maxq_state,
  input  logic          maxq_done,
  input  logic [1:0]    maxq_action,
  output logic          upd_start,
  output logic [5:0]    upd_state,
  output logic [1:0]    upd_action,
  input  logic          upd_done,
  output logic          trial_start,
  output logic [5:0]    trial_state,
  output logic [1:0]    trial_action,
  input  logic          trial_done,
  input  logic [5:0]    trial_next,
  output logic [EW-1:0] episode,
  output logic [SW-1:0] step,
  output logic          busy,
  output logic          learn_done,
  output logic          fault
);

  typedef enum logic [2:0] {
    IDLE, EP_CHECK, MAXQ, UPDATE, TRIAL, STEP_END, DONE, FAULT
  } state_t;

  localparam logic [EW-1:0] EP_MAX   = EW'(N_EPISODES);
  localparam logic [SW-1:0] STEP_MAX = SW'(MAX_STEPS);

  state_t      state, nxt;
  logic [5:0]  cur_state;
  logic [1:0]  act;
  logic        fresh;  // first cycle in a wait state: start pulse out, done ignored
  logic        maxq_acc, upd_acc, trial_acc, ep_end, enter_wait, wd_expired;

  assign maxq_acc   = (state == MAXQ)   && !fresh && maxq_done;
  assign upd_acc    = (state == UPDATE) && !fresh && upd_done;
  assign trial_acc  = (state == TRIAL)  && !fresh && trial_done;
  assign ep_end     = (cur_state == target_state) || (step == STEP_MAX);
  assign enter_wait = (nxt != state) && (nxt inside {MAXQ, UPDATE, TRIAL});

`ifdef Q_SEQ_WATCHDOG_EN
  logic [7:0] wdog;
  assign wd_expired = (wdog == 8'hFF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wdog <= '0;
    else if (enter_wait)
      wdog <= '0;
    else if (state inside {MAXQ, UPDATE, TRIAL})
      wdog <= wdog + 8'd1;
  end
`else
  assign wd_expired = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:     if (init_done) nxt = EP_CHECK;
      EP_CHECK: if (episode == EP_MAX) nxt = DONE;
                else if (cur_state != target_state) nxt = MAXQ;
      MAXQ:     if (maxq_acc) nxt = UPDATE;
                else if (wd_expired) nxt = FAULT;
      UPDATE:   if (upd_acc) nxt = TRIAL;
                else if (wd_expired) nxt = FAULT;
      TRIAL:    if (trial_acc) nxt = STEP_END;
                else if (wd_expired) nxt = FAULT;
      STEP_END: nxt = ep_end ? EP_CHECK : MAXQ;
      DONE:     nxt = DONE;
      FAULT:    nxt = FAULT;
      default:  nxt = IDLE;
    endcase
  end

  always_comb begin
    maxq_start  = (state == MAXQ)   && fresh;
    upd_start   = (state == UPDATE) && fresh;
    trial_start = (state == TRIAL)  && fresh;
    busy        = !(state inside {IDLE, DONE, FAULT});
    learn_done  = (state == DONE);
`ifdef Q_SEQ_WATCHDOG_EN
    fault       = (state == FAULT);
`else
    fault       = 1'b0;
`endif
  end

  // Counters saturate so their widths never wrap, even if a guard is bypassed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fresh     <= 1'b0;
      cur_state <= '0;
      act       <= '0;
      episode   <= '0;
      step      <= '0;
    end else begin
      fresh <= enter_wait;
      case (state)
        IDLE:
          if (init_done) cur_state <= start_state;
        EP_CHECK:
          if (episode != EP_MAX && cur_state == target_state) begin
            episode   <= episode + EW'(1);
            cur_state <= start_state;
          end
        MAXQ:
          if (maxq_acc) act <= maxq_action;
        TRIAL:
          if (trial_acc) begin
            cur_state <= trial_next;
            if (step != STEP_MAX) step <= step + SW'(1);
          end
        STEP_END:
          if (ep_end) begin
            if (episode != EP_MAX) episode <= episode + EW'(1);
            step      <= '0;
            cur_state <= start_state;
          end
        default: ;
      endcase
    end
  end

  assign maxq_state   = cur_state;
  assign upd_state    = cur_state;
  assign trial_state  = cur_state;
  assign upd_action   = act;
  assign trial_action = act;

endmodule

// File: tb/tb_q_episode_sequencer.sv
// Bench for q_episode_sequencer: a reference model expands each run into the expected sub-op sequence,
// randomized responders answer the handshakes, and a monitor scores every start pulse against the queue.
module tb_q_episode_sequencer;

  localparam int N  = 11;
  localparam int M  = 36;
  localparam int EW = $clog2(N + 1);
  localparam int SW = $clog2(M + 1);

  logic          clk, rst, init_done;
  logic [5:0]    start_state, target_state;
  logic          maxq_start, maxq_done;
  logic [5:0]    maxq_state;
  logic [1:0]    maxq_action;
  logic          upd_start, upd_done;
  logic [5:0]    upd_state;
  logic [1:0]    upd_action;
  logic          trial_start, trial_done;
  logic [5:0]    trial_state, trial_next;
  logic [1:0]    trial_action;
  logic [EW-1:0] episode;
  logic [SW-1:0] step;
  logic          busy, learn_done, fault;

  q_episode_sequencer #(.N_EPISODES(N), .MAX_STEPS(M)) dut (
    .clk(clk), .rst(rst), .init_done(init_done),
    .start_state(start_state), .target_state(target_state),
    .maxq_start(maxq_start), .maxq_state(maxq_state),
    .maxq_done(maxq_done), .maxq_action(maxq_action),
    .upd_start(upd_start), .upd_state(upd_state), .upd_action(upd_action),
    .upd_done(upd_done),
    .trial_start(trial_start), .trial_state(trial_state), .trial_action(trial_action),
    .trial_done(trial_done), .trial_next(trial_next),
    .episode(episode), .step(step), .busy(busy),
    .learn_done(learn_done), .fault(fault)
  );

  typedef struct {
    int         kind;  // 0 maxq, 1 update, 2 trial
    logic [5:0] st;
    logic [1:0] a;
    int         ep;
    int         stp;
  } exp_t;

  exp_t       expq[$];
  logic [1:0] stim_act[$];
  logic [5:0] stim_nxt[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int exp_total;
  bit fast, hold, slow, upd_block;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "bench did not finish");
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s got=%0d required=%0d at t=%0t", nm, got, req, $time);
    end
  endtask

  function automatic int dly();
    if (slow) return 4;
    if (fast) return 1;
    return $urandom_range(1, 4);
  endfunction

  // Episode-level model: walk each episode from start until target or step limit.
  task automatic build_run(input logic [5:0] s, input logic [5:0] t, input bit blocked);
    logic [5:0] cur, nx;
    logic [1:0] a;
    int n, r;
    expq.delete(); stim_act.delete(); stim_nxt.delete();
    exp_total = N + 1;
    for (int ep = 0; ep < N; ep++) begin
      cur = s;
      n = 0;
      while (cur != t && n < M) begin
        a = 2'($urandom);
        r = $urandom_range(0, 3);
        if (blocked || r == 1) nx = cur;
        else if (r == 0)       nx = t;
        else                   nx = 6'($urandom);
        expq.push_back('{kind: 0, st: cur, a: a, ep: ep, stp: n});
        expq.push_back('{kind: 1, st: cur, a: a, ep: ep, stp: n});
        expq.push_back('{kind: 2, st: cur, a: a, ep: ep, stp: n});
        stim_act.push_back(a);
        stim_nxt.push_back(nx);
        cur = nx;
        n++;
        exp_total += 7;
      end
    end
  endtask

  task automatic pop_chk(input int k, input logic [5:0] st, input logic [1:0] a);
    exp_t e;
    if (expq.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_start kind=%0d got a start pulse, required none", k);
      return;
    end
    e = expq.pop_front();
    chk("start_kind", k, e.kind);
    chk("start_state", st, e.st);
    if (k != 0) chk("start_action", a, e.a);
    chk("start_episode", episode, e.ep);
    chk("start_step", step, e.stp);
  endtask

  // Monitor
  initial begin
    bit pm, pu, pt;
    int t_m;
    pm = 0; pu = 0; pt = 0; t_m = 0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) begin
        pm = 0; pu = 0; pt = 0;
      end else begin
        if (pm) chk("maxq_one_cycle", maxq_start, 0);
        if (pu) chk("upd_one_cycle", upd_start, 0);
        if (pt) chk("trial_one_cycle", trial_start, 0);
        if (maxq_start) begin
          pop_chk(0, maxq_state, 2'd0);
          t_m = cyc;
        end
        if (upd_start) begin
          pop_chk(1, upd_state, upd_action);
          if (hold || fast) chk("maxq_accept_latency", cyc - t_m, 2);
        end
        if (trial_start) pop_chk(2, trial_state, trial_action);
        if (learn_done) chk("starts_in_done", {maxq_start, upd_start, trial_start}, 0);
        pm = maxq_start; pu = upd_start; pt = trial_start;
      end
    end
  end

  // Responders
  initial begin
    logic [1:0] a;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && maxq_start) begin
        a = (stim_act.size() != 0) ? stim_act.pop_front() : 2'd0;
        if (hold) begin
          maxq_action = a;
          @(negedge clk);
          @(negedge clk);
          maxq_action = 2'($urandom);
        end else begin
          repeat (dly() - 1) @(negedge clk);
          @(negedge clk);
          maxq_action = a;
          maxq_done = 1'b1;
          @(negedge clk);
          maxq_done = 1'b0;
          maxq_action = 2'($urandom);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && upd_start && !upd_block) begin
        repeat (dly()) @(negedge clk);
        upd_done = 1'b1;
        @(negedge clk);
        upd_done = 1'b0;
      end
    end
  end

  initial begin
    logic [5:0] nx;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && trial_start) begin
        nx = (stim_nxt.size() != 0) ? stim_nxt.pop_front() : trial_state;
        repeat (dly()) @(negedge clk);
        trial_next = nx;
        trial_done = 1'b1;
        @(negedge clk);
        trial_done = 1'b0;
        trial_next = 6'($urandom);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_starts"}, {maxq_start, upd_start, trial_start}, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_learn_done"}, learn_done, 0);
    chk({tag, "_fault"}, fault, 0);
    chk({tag, "_episode"}, episode, 0);
    chk({tag, "_step"}, step, 0);
    chk({tag, "_cur_state"}, maxq_state, 0);
    chk({tag, "_act"}, upd_action, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    init_done = 1'b0;
    maxq_done = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic run(input logic [5:0] s, input logic [5:0] t, input bit blocked,
                     input bit f, input bit h);
    int n;
    fast = f;
    hold = h;
    build_run(s, t, blocked);
    start_state  = s;
    target_state = t;
    maxq_done    = h;
    @(negedge clk);
    init_done = 1'b1;
    n = 0;
    while (!learn_done && n < 30000) begin
      @(negedge clk);
      n++;
    end
    chk("learn_done_seen", learn_done, 1);
    if (f) chk("done_latency", n - 1, exp_total);
    chk("expected_drained", expq.size(), 0);
    chk("episode_final", episode, N);
    chk("step_final", step, 0);
    chk("busy_in_done", busy, 0);
    chk("fault_in_done", fault, 0);
    repeat (5) @(negedge clk);
    chk("learn_done_held", learn_done, 1);
    maxq_done = 1'b0;
    init_done = 1'b0;
  endtask

  function automatic logic [5:0] other(input logic [5:0] s);
    return s + 6'($urandom_range(1, 63));
  endfunction

  initial begin
    logic [5:0] s;
    int k;
    rst = 1'b1;
    init_done = 1'b0;
    start_state = '0; target_state = '0;
    maxq_done = 1'b0; maxq_action = '0;
    upd_done = 1'b0;
    trial_done = 1'b0; trial_next = '0;
    fast = 0; hold = 0; slow = 0; upd_block = 0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_without_init", busy, 0);

    s = 6'($urandom); run(s, other(s), 0, 0, 0);
    do_reset();
    s = 6'($urandom); run(s, other(s), 0, 1, 0);
    do_reset();
    s = 6'($urandom); run(s, other(s), 1, 1, 1);
    do_reset();
    s = 6'($urandom); run(s, s, 0, 1, 0);
    do_reset();

    // Abort mid-TRIAL with trial_done still pending.
    fast = 0; hold = 0; slow = 1;
    s = 6'($urandom);
    build_run(s, other(s), 0);
    start_state = s;
    target_state = expq[0].st == s ? other(s) : s;
    target_state = other(s);
    build_run(s, target_state, 0);
    @(negedge clk);
    init_done = 1'b1;
    k = 0;
    while (!trial_start && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("trial_start_seen", trial_start, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_reset");
    init_done = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    slow = 0;
    repeat (10) @(negedge clk);
    chk("idle_after_abort", busy, 0);
    s = 6'($urandom); run(s, other(s), 0, 0, 0);

`ifdef Q_SEQ_WATCHDOG_EN
    do_reset();
    fast = 1; upd_block = 1;
    s = 6'($urandom);
    start_state = s;
    target_state = other(s);
    build_run(s, target_state, 0);
    @(negedge clk);
    init_done = 1'b1;
    k = 0;
    while (!upd_start && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("upd_start_seen", upd_start, 1);
    repeat (255) @(negedge clk);
    chk("fault_before_256", fault, 0);
    @(negedge clk);
    chk("fault_at_256", fault, 1);
    chk("busy_in_fault", busy, 0);
    k = 0;
    repeat (10) begin
      @(negedge clk);
      if (maxq_start || upd_start || trial_start) k++;
    end
    chk("no_starts_in_fault", k, 0);
    chk("fault_held", fault, 1);
    upd_block = 0;
    do_reset();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
